// File: rtl/instr_fetch.sv
// Instruction fetch stage: requests one word at pc, holds it for decode,
// then advances to pc+4 or a branch target. A misaligned target parks the
// stage in a sticky fault state until reset.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        PCSrc,
  input  logic [31:0] PCTarget,
  output logic [31:0] instr,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic        funct7_5,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fault
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] next_pc;

  // Sequential address, wraps modulo 2^32
  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;

  // Candidate address on retire; only consumed in VALID with instr_ready
  assign next_pc = PCSrc ? PCTarget : pc_plus4;

  // Decode-field slices of the held instruction
  assign op       = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7_5 = instr[30];
  assign rd       = instr[11:7];
  assign rs1      = instr[19:15];
  assign rs2      = instr[24:20];

  // Fetch FSM with registered request/valid/fault outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= NOP_INSTR;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_ready) begin
            instr       <= imem_rdata;
            state       <= VALID;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
          end
        end
        VALID: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            if (next_pc[1:0] == 2'b00) begin
              pc       <= next_pc;
              state    <= FETCH;
              imem_req <= 1'b1;
            end else begin
              // Misaligned target: keep pc pointing at the offending branch
              state <= FAULT;
              fault <= 1'b1;
            end
          end
        end
        FAULT: begin
          state <= FAULT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a scoreboard queue of expected retirements
// checked by a negedge monitor, plus inline checks of request/fault behaviour.
module tb_instr_fetch;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic        PCSrc;
  logic [31:0] PCTarget;
  logic [31:0] instr;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fault;

  // Second instance for the top-of-address-space wrap case
  logic        w_reset;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_ready;
  logic [31:0] w_rdata;
  logic        w_valid;
  logic        w_iready;
  logic        w_pcsrc;
  logic [31:0] w_target;
  logic [31:0] w_instr;
  logic [6:0]  w_op;
  logic [2:0]  w_funct3;
  logic        w_funct7_5;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [31:0] w_pc;
  logic [31:0] w_pc_plus4;
  logic        w_fault;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } retire_t;

  retire_t exp_q[$];
  int      checks = 0;
  int      errors = 0;

  instr_fetch #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .PCSrc(PCSrc), .PCTarget(PCTarget),
    .instr(instr), .op(op), .funct3(funct3), .funct7_5(funct7_5),
    .rd(rd), .rs1(rs1), .rs2(rs2),
    .pc(pc), .pc_plus4(pc_plus4), .fault(fault)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .reset(w_reset),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_ready(w_ready), .imem_rdata(w_rdata),
    .instr_valid(w_valid), .instr_ready(w_iready),
    .PCSrc(w_pcsrc), .PCTarget(w_target),
    .instr(w_instr), .op(w_op), .funct3(w_funct3), .funct7_5(w_funct7_5),
    .rd(w_rd), .rs1(w_rs1), .rs2(w_rs2),
    .pc(w_pc), .pc_plus4(w_pc_plus4), .fault(w_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image: a beq at 0xC, otherwise an address-tagged word
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_000C) return 32'h0020_8463;
    return {a[23:0], 8'h13};
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] p, input logic [31:0] w);
    retire_t e;
    e.pc    = p;
    e.instr = w;
    exp_q.push_back(e);
  endtask

  // Retire monitor: every accepted instruction must match the next expected entry
  always @(negedge clk) begin
    if (!reset && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL retire_unexpected: got pc %h expected no retire", pc);
      end else begin
        retire_t e;
        e = exp_q.pop_front();
        chk("retire_pc", pc, e.pc);
        chk("retire_instr", instr, e.instr);
      end
    end
  end

  initial begin
    reset       = 1'b1;
    imem_ready  = 1'b0;
    instr_ready = 1'b0;
    PCSrc       = 1'b0;
    PCTarget    = 32'h0;
    w_reset     = 1'b1;
    w_ready     = 1'b1;
    w_rdata     = 32'h0000_0013;
    w_iready    = 1'b0;
    w_pcsrc     = 1'b0;
    w_target    = 32'h0;

    // Reset values
    next_cycle();
    next_cycle();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_op", 32'(op), 32'h13);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_pc_plus4", pc_plus4, 32'h4);

    // Zero-wait memory, always-ready decode: 0x0, 0x4, 0x8 every 2 cycles
    imem_ready  = 1'b1;
    instr_ready = 1'b1;
    PCTarget    = 32'h3;
    push_exp(32'h0, mem_word(32'h0));
    push_exp(32'h4, mem_word(32'h4));
    push_exp(32'h8, mem_word(32'h8));
    reset = 1'b0;
    chk("idle_req", 32'(imem_req), 32'd0);
    next_cycle();
    chk("req0", 32'(imem_req), 32'd1);
    chk("addr0", imem_addr, 32'h0);
    next_cycle();
    chk("valid0", 32'(instr_valid), 32'd1);
    chk("valid0_req", 32'(imem_req), 32'd0);
    next_cycle();
    chk("req4", 32'(imem_req), 32'd1);
    chk("addr4", imem_addr, 32'h4);
    next_cycle();
    next_cycle();
    chk("req8", 32'(imem_req), 32'd1);
    chk("addr8", imem_addr, 32'h8);
    instr_ready = 1'b0;

    // Held instruction stays put while decode stalls and PCSrc toggles
    next_cycle();
    PCTarget = 32'h200;
    for (int i = 0; i < 4; i++) begin
      PCSrc = ~PCSrc;
      next_cycle();
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_req", 32'(imem_req), 32'd0);
      chk("stall_pc", pc, 32'h8);
      chk("stall_instr", instr, mem_word(32'h8));
    end

    // Retire 0x8, then memory stalls in FETCH at 0xC
    PCSrc       = 1'b0;
    instr_ready = 1'b1;
    imem_ready  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      chk("wait_req", 32'(imem_req), 32'd1);
      chk("wait_addr", imem_addr, 32'hC);
      chk("wait_instr", instr, mem_word(32'h8));
    end

    // Memory returns the beq; taken branch to 0x100
    imem_ready = 1'b1;
    PCSrc      = 1'b1;
    PCTarget   = 32'h100;
    push_exp(32'hC, 32'h0020_8463);
    next_cycle();
    chk("beq_valid", 32'(instr_valid), 32'd1);
    chk("beq_op", 32'(op), 32'h63);
    chk("beq_funct3", 32'(funct3), 32'd0);
    chk("beq_rs1", 32'(rs1), 32'd1);
    chk("beq_rs2", 32'(rs2), 32'd2);
    chk("beq_rd", 32'(rd), 32'd8);
    chk("beq_funct7_5", 32'(funct7_5), 32'd0);
    next_cycle();
    chk("br_req", 32'(imem_req), 32'd1);
    chk("br_addr", imem_addr, 32'h100);
    chk("br_pc_plus4", pc_plus4, 32'h104);

    // Taken branch to a misaligned target faults and sticks
    PCTarget = 32'h102;
    push_exp(32'h100, mem_word(32'h100));
    next_cycle();
    chk("pre_fault_valid", 32'(instr_valid), 32'd1);
    next_cycle();
    chk("fault_set", 32'(fault), 32'd1);
    chk("fault_req", 32'(imem_req), 32'd0);
    chk("fault_valid", 32'(instr_valid), 32'd0);
    chk("fault_pc", imem_addr, 32'h100);
    for (int i = 0; i < 3; i++) begin
      PCSrc = ~PCSrc;
      next_cycle();
      chk("fault_sticky", 32'(fault), 32'd1);
      chk("fault_sticky_req", 32'(imem_req), 32'd0);
      chk("fault_sticky_valid", 32'(instr_valid), 32'd0);
    end

    // Asynchronous reset clears the fault immediately
    reset = 1'b1;
    #1;
    chk("arst_fault", 32'(fault), 32'd0);
    chk("arst_addr", imem_addr, 32'h0);
    chk("arst_op", 32'(op), 32'h13);

    // Reset during an outstanding request drops it without loading
    next_cycle();
    imem_ready = 1'b0;
    reset      = 1'b0;
    next_cycle();
    chk("refetch_req", 32'(imem_req), 32'd1);
    chk("refetch_addr", imem_addr, 32'h0);
    reset = 1'b1;
    #1;
    chk("abort_req", 32'(imem_req), 32'd0);
    chk("abort_instr", instr, 32'h0000_0013);

    // Wrap from 0xFFFF_FFFC to 0x0 on a sequential retire
    next_cycle();
    w_reset = 1'b0;
    chk("wrap_idle_req", 32'(w_req), 32'd0);
    next_cycle();
    chk("wrap_req", 32'(w_req), 32'd1);
    chk("wrap_addr", w_addr, 32'hFFFF_FFFC);
    chk("wrap_pc_plus4", w_pc_plus4, 32'h0);
    next_cycle();
    chk("wrap_valid", 32'(w_valid), 32'd1);
    w_iready = 1'b1;
    next_cycle();
    chk("wrap_next_req", 32'(w_req), 32'd1);
    chk("wrap_next_addr", w_addr, 32'h0);
    chk("wrap_fault", 32'(w_fault), 32'd0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
